// File: rtl/mem_bus_arbiter.sv
// N-client line-memory arbiter: merges upstream cache channels onto one memory bus, tags requests
// with the client index and routes responses back. Define MEM_BUS_ARB_FIXED_PRIO_EN for fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned CID_W       = 2,
  parameter int unsigned MAX_OUTST   = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 128,
  localparam int unsigned IDX_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        c_req_valid,
  output logic [NUM_CLIENTS-1:0]        c_req_ready,
  input  logic [NUM_CLIENTS*CID_W-1:0]  c_req_id,
  input  logic [NUM_CLIENTS-1:0]        c_req_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] c_req_addr,
  input  logic [NUM_CLIENTS*LINE_W-1:0] c_req_data,
  output logic [NUM_CLIENTS-1:0]        c_resp_valid,
  input  logic [NUM_CLIENTS-1:0]        c_resp_ready,
  output logic [CID_W-1:0]              c_resp_id,
  output logic [LINE_W-1:0]             c_resp_data,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic                          m_req_we,
  output logic [ADDR_W-1:0]             m_req_addr,
  output logic [LINE_W-1:0]             m_req_data,
  output logic [IDX_W+CID_W-1:0]        m_req_id,
  input  logic                          m_resp_valid,
  output logic                          m_resp_ready,
  input  logic [IDX_W+CID_W-1:0]        m_resp_id,
  input  logic [LINE_W-1:0]             m_resp_data,
  output logic [NUM_CLIENTS*4-1:0]      outst_cnt,
  output logic                          err
);

  localparam int N = int'(NUM_CLIENTS);
  localparam logic [3:0] MaxCnt = 4'(MAX_OUTST);

  logic [3:0]             cnt_q [NUM_CLIENTS];
  logic                   lock_q;
  logic [IDX_W-1:0]       lock_idx_q;
  logic                   err_q;
  logic [NUM_CLIENTS-1:0] elig;
  logic                   gnt_vld;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   m_req_hs;
  logic                   m_resp_hs;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_ok;
  logic                   r_ready;
  logic [CID_W-1:0]       gnt_cid;
  logic [NUM_CLIENTS-1:0] cnt_inc;
  logic [NUM_CLIENTS-1:0] cnt_dec;

  // Reset gates eligibility so nothing is granted while rst is low.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = rst && c_req_valid[i] && (cnt_q[i] < MaxCnt);
    end
  end

`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q;

  // Scan downwards so the client closest to rr_ptr is assigned last and wins.
  always_comb begin
    int p;
    p       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(rr_ptr_q) + k;
      if (p >= N) p = p - N;
      if (elig[p]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(p);
      end
    end
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else if (m_req_hs) begin
      rr_ptr_q <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    m_req_we    = 1'b0;
    m_req_addr  = '0;
    m_req_data  = '0;
    gnt_cid     = '0;
    c_req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_vld && gnt_idx == IDX_W'(i)) begin
        m_req_we       = c_req_we[i];
        m_req_addr     = c_req_addr[i*ADDR_W +: ADDR_W];
        m_req_data     = c_req_data[i*LINE_W +: LINE_W];
        gnt_cid        = c_req_id[i*CID_W +: CID_W];
        c_req_ready[i] = m_req_ready;
      end
    end
  end

  assign m_req_valid = gnt_vld;
  assign m_req_id    = {gnt_idx, gnt_cid};
  assign m_req_hs    = gnt_vld & m_req_ready;

  // Responses to unknown clients or idle counters are swallowed (ready=1) and flagged.
  assign r_idx = m_resp_id[IDX_W+CID_W-1 -: IDX_W];

  always_comb begin
    r_ok         = 1'b0;
    r_ready      = 1'b1;
    c_resp_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IDX_W'(i) && cnt_q[i] != 4'd0) begin
        r_ok            = 1'b1;
        r_ready         = c_resp_ready[i];
        c_resp_valid[i] = m_resp_valid & rst;
      end
    end
  end

  assign m_resp_ready = rst & r_ready;
  assign m_resp_hs    = m_resp_valid & m_resp_ready;
  assign c_resp_id    = m_resp_id[CID_W-1:0];
  assign c_resp_data  = m_resp_data;

  always_comb begin
    cnt_inc   = '0;
    cnt_dec   = '0;
    outst_cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt_inc[i]          = m_req_hs && gnt_idx == IDX_W'(i);
      cnt_dec[i]          = m_resp_hs && r_ok && r_idx == IDX_W'(i);
      outst_cnt[i*4 +: 4] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 4'd0;
    end else begin
      if (m_req_hs) begin
        lock_q <= 1'b0;
      end else if (gnt_vld) begin
        lock_q     <= 1'b1;
        lock_idx_q <= gnt_idx;
      end
      if (m_resp_valid && !r_ok) err_q <= 1'b1;
      for (int i = 0; i < N; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) cnt_q[i] <= cnt_q[i] + 4'd1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 4'd1;
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with two clients.
module tb_mem_bus_arbiter;

  localparam int unsigned NC  = 2;
  localparam int unsigned CW  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 128;
  localparam int unsigned IW  = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NC-1:0]      c_req_valid;
  logic [NC-1:0]      c_req_ready;
  logic [NC*CW-1:0]   c_req_id;
  logic [NC-1:0]      c_req_we;
  logic [NC*AW-1:0]   c_req_addr;
  logic [NC*LW-1:0]   c_req_data;
  logic [NC-1:0]      c_resp_valid;
  logic [NC-1:0]      c_resp_ready;
  logic [CW-1:0]      c_resp_id;
  logic [LW-1:0]      c_resp_data;
  logic               m_req_valid;
  logic               m_req_ready;
  logic               m_req_we;
  logic [AW-1:0]      m_req_addr;
  logic [LW-1:0]      m_req_data;
  logic [IW+CW-1:0]   m_req_id;
  logic               m_resp_valid;
  logic               m_resp_ready;
  logic [IW+CW-1:0]   m_resp_id;
  logic [LW-1:0]      m_resp_data;
  logic [NC*4-1:0]    outst_cnt;
  logic               err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .NUM_CLIENTS(NC),
    .CID_W      (CW),
    .MAX_OUTST  (4),
    .ADDR_W     (AW),
    .LINE_W     (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .c_req_valid (c_req_valid),
    .c_req_ready (c_req_ready),
    .c_req_id    (c_req_id),
    .c_req_we    (c_req_we),
    .c_req_addr  (c_req_addr),
    .c_req_data  (c_req_data),
    .c_resp_valid(c_resp_valid),
    .c_resp_ready(c_resp_ready),
    .c_resp_id   (c_resp_id),
    .c_resp_data (c_resp_data),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_we    (m_req_we),
    .m_req_addr  (m_req_addr),
    .m_req_data  (m_req_data),
    .m_req_id    (m_req_id),
    .m_resp_valid(m_resp_valid),
    .m_resp_ready(m_resp_ready),
    .m_resp_id   (m_resp_id),
    .m_resp_data (m_resp_data),
    .outst_cnt   (outst_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req_valid  = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_id    = '0;
    m_resp_data  = '0;
    c_resp_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #1;
    tick();
    rst = 1'b1;
    #1;
  endtask

  logic [1:0]  exp_rdy  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [2:0]  exp_id   [4] = '{3'b001, 3'b110, 3'b001, 3'b110};
  logic [31:0] exp_addr [4] = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
  logic        exp_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Client 0: id 1, addr A0, read; client 1: id 2, addr B0, write.
    c_req_id   = {2'd2, 2'd1};
    c_req_we   = 2'b10;
    c_req_addr = {32'hB0, 32'hA0};
    c_req_data = {128'h1111, 128'h2222};
    rst = 1'b0;
    idle();
    c_req_valid  = 2'b11;
    m_req_ready  = 1'b1;
    m_resp_valid = 1'b1;
    c_resp_ready = 2'b11;
    #3;
    check("rst_m_req_valid", m_req_valid, 1'b0);
    check("rst_c_req_ready", c_req_ready, 2'b00);
    check("rst_c_resp_valid", c_resp_valid, 2'b00);
    check("rst_m_resp_ready", m_resp_ready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cnt", outst_cnt, 8'h00);
    idle();
    tick();
    rst = 1'b1;
    #1;

    // Round-robin with both clients valid.
    c_req_valid = 2'b11;
    m_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", c_req_ready, exp_rdy[k]);
      check("rr_id", m_req_id, exp_id[k]);
      check("rr_addr", m_req_addr, exp_addr[k]);
      check("rr_we", m_req_we, exp_we[k]);
      tick();
    end
    idle();
    #1;
    check("rr_cnt", outst_cnt, 8'h22);
    m_resp_valid = 1'b1;
    m_resp_id    = 3'b001;
    m_resp_data  = 128'hCAFE;
    c_resp_ready = 2'b01;
    #1;
    check("resp_valid", c_resp_valid, 2'b01);
    check("resp_mready", m_resp_ready, 1'b1);
    check("resp_id", c_resp_id, 2'd1);
    check("resp_data", c_resp_data, 128'hCAFE);
    tick();
    idle();
    #1;
    check("resp_cnt", outst_cnt, 8'h21);

    // Grant lock while downstream stalls.
    do_reset();
    c_req_valid = 2'b10;
    #1;
    check("lock_ready0", c_req_ready, 2'b00);
    check("lock_mvalid", m_req_valid, 1'b1);
    check("lock_idx0", m_req_id[2], 1'b1);
    tick();
    c_req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("lock_hold", m_req_id[2], 1'b1);
      tick();
    end
    m_req_ready = 1'b1;
    #1;
    check("lock_hs", c_req_ready, 2'b10);
    tick();
    #1;
    check("after_lock", c_req_ready, 2'b01);
    tick();
    idle();
    #1;
    check("lock_cnt", outst_cnt, 8'h11);

    // Outstanding limit for client 0.
    do_reset();
    c_req_valid = 2'b01;
    m_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("lim_accept", c_req_ready, 2'b01);
      tick();
    end
    #1;
    check("lim_cnt4", outst_cnt, 8'h04);
    check("lim_block", c_req_ready, 2'b00);
    check("lim_mvalid", m_req_valid, 1'b0);
    m_resp_valid = 1'b1;
    m_resp_id    = 3'b000;
    c_resp_ready = 2'b01;
    #1;
    check("lim_same_cycle", c_req_ready, 2'b00);
    check("lim_resp_ready", m_resp_ready, 1'b1);
    tick();
    #1;
    check("lim_reopen", c_req_ready, 2'b01);
    check("lim_both_rdy", m_resp_ready, 1'b1);
    check("lim_cnt3", outst_cnt, 8'h03);
    tick();
    idle();
    #1;
    check("lim_req_resp", outst_cnt, 8'h03);

    // Response backpressure to client 1.
    do_reset();
    c_req_valid = 2'b10;
    m_req_ready = 1'b1;
    tick();
    idle();
    m_resp_valid = 1'b1;
    m_resp_id    = 3'b110;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("bp_mready", m_resp_ready, 1'b0);
      check("bp_valid", c_resp_valid, 2'b10);
      check("bp_id", c_resp_id, 2'd2);
      tick();
    end
    c_resp_ready = 2'b10;
    #1;
    check("bp_release", m_resp_ready, 1'b1);
    tick();
    idle();
    #1;
    check("bp_cnt", outst_cnt, 8'h00);
    check("bp_err", err, 1'b0);

    // Stray response to an idle client.
    m_resp_valid = 1'b1;
    m_resp_id    = 3'b000;
    #1;
    check("drop_mready", m_resp_ready, 1'b1);
    check("drop_valid", c_resp_valid, 2'b00);
    tick();
    idle();
    #1;
    check("drop_err", err, 1'b1);
    check("drop_cnt", outst_cnt, 8'h00);
    tick();
    tick();
    check("err_sticky", err, 1'b1);

    // Reset asserted with two requests in flight.
    do_reset();
    check("rst2_err", err, 1'b0);
    c_req_valid = 2'b01;
    m_req_ready = 1'b1;
    tick();
    tick();
    #1;
    check("mid_cnt", outst_cnt, 8'h02);
    rst          = 1'b0;
    m_resp_valid = 1'b1;
    m_resp_id    = 3'b000;
    c_resp_ready = 2'b01;
    #1;
    check("mid_mvalid", m_req_valid, 1'b0);
    check("mid_ready", c_req_ready, 2'b00);
    check("mid_rvalid", c_resp_valid, 2'b00);
    check("mid_mready", m_resp_ready, 1'b0);
    check("mid_cnt0", outst_cnt, 8'h00);
    idle();
    tick();
    rst = 1'b1;
    #1;
    check("post_cnt", outst_cnt, 8'h00);
    m_resp_valid = 1'b1;
    m_resp_id    = 3'b000;
    c_resp_ready = 2'b01;
    #1;
    check("stale_drop", c_resp_valid, 2'b00);
    check("stale_mready", m_resp_ready, 1'b1);
    tick();
    idle();
    #1;
    check("stale_err", err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
